sound_sdr_arb: RTL
==================

SOUND_SDR_ARB -- requirements
Module: sound_sdr_arb

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning: 0 selects round-robin arbitration; 1 makes port 0 always win contention.
REQ-002 Parameter AW, default 25, meaning: SDRAM address width.
REQ-003 clk  input  1  the single clock; all logic is rising-edge clocked on it.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  port 0 level request; held high with addr0 stable until rdy0 is seen.
REQ-006 addr0  input  AW  port 0 64-bit line address.
REQ-007 rdy0  output  1  one-cycle pulse; dout0 is valid in this cycle.
REQ-008 dout0  output  64  port 0 returned line.
REQ-009 req1, addr1, rdy1, dout1  as REQ-005..REQ-008, but for port 1.
REQ-010 sdr_addr  output  AW  address presented to the SDRAM channel.
REQ-011 sdr_req  output  1  level request to the SDRAM channel.
REQ-012 sdr_data  input  64  SDRAM read data, valid while sdr_rdy is high.
REQ-013 sdr_rdy  input  1  one-cycle completion pulse from the SDRAM channel.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-016 In IDLE with at least one reqN high, the block SHALL latch the winning port and its address and enter BUSY on the next edge.
REQ-017 sdr_req and sdr_addr SHALL be registered and SHALL assert on the first BUSY cycle, which is one cycle after the IDLE sample.
REQ-018 sdr_addr SHALL remain constant throughout BUSY, even if addrN changes.
REQ-019 In BUSY, sdr_req SHALL stay high until the cycle in which sdr_rdy is sampled high.
REQ-020 On that cycle the block SHALL capture sdr_data into the granted port's doutN, deassert sdr_req, and enter DONE.
REQ-021 In DONE, the granted port's rdyN SHALL be high for exactly one cycle, and the block SHALL return to IDLE on the next edge.
REQ-022 The latency from sdr_rdy to rdyN SHALL be 1 cycle.
REQ-023 sdr_req SHALL be low for at least 2 cycles (DONE and IDLE) between transactions.
REQ-024 doutN SHALL hold its last captured value until the next completion on that port; the other port's dout SHALL be unchanged by a completion.
REQ-025 Contention when FIXED_PRIO=0: if both reqs are high in IDLE, the port not served last SHALL win; after reset, port 0 counts as last served, so port 1 wins the first tie.
REQ-026 Contention when FIXED_PRIO=1: port 0 SHALL always win.
REQ-027 A single requesting port SHALL win regardless of the priority mode.
REQ-028 If the granted port drops reqN during BUSY, the SDRAM transaction SHALL still complete, and rdyN SHALL be suppressed.
REQ-029 sdr_rdy sampled in IDLE or DONE SHALL be ignored, with no state change and no dout update.
REQ-030 A reqN that rises during BUSY or DONE SHALL be considered only at the next IDLE cycle.
REQ-031 A port served in one transaction SHALL NOT be re-granted from the same request: its req is sampled low in IDLE under the REQ-005 protocol.

Reset
REQ-032 Reset SHALL force: state=IDLE, sdr_req=0, sdr_addr=0, rdy0=rdy1=0, dout0=dout1=0, busy=0, last-served=port 0.
REQ-033 Reset asserted mid-BUSY SHALL abandon the transaction: sdr_req falls on the next edge and no rdy pulse is issued.
REQ-034 An sdr_rdy arriving after reset releases SHALL be ignored, per REQ-029.

Structure
REQ-035 The state enumeration and the 64-bit line width constant SHALL live in the shared sound package, for reuse by ga20_cache.
REQ-036 The grant selection (priority mode plus last-served) SHALL be a sub-module named sound_sdr_arb_pick; everything else is flat in one module.

Verification
REQ-037 Single request: req0=1, addr0=25'h012345; SDRAM returns 64'hDEADBEEF_01234567 two cycles after sdr_req -> sdr_addr=25'h012345; rdy0 pulses one cycle after sdr_rdy with dout0=64'hDEADBEEF_01234567; rdy1 stays 0.
REQ-038 Tie with FIXED_PRIO=0: both reqs rise together after reset, addr0=25'h100, addr1=25'h200 -> first sdr_addr=25'h200, second sdr_addr=25'h100, with a gap of at least 2 cycles of sdr_req low between them.
REQ-039 Tie with FIXED_PRIO=1 and port 0 re-requesting three times -> three consecutive grants to port 0; port 1 is served only after req0 stays low.
REQ-040 Drop mid-BUSY: req1 falls while BUSY -> sdr_rdy is still consumed, no rdy1 pulse, dout1 updated, next state sequence DONE then IDLE.
REQ-041 Reset mid-BUSY followed by a stray sdr_rdy 3 cycles later -> sdr_req=0 after one edge; no rdy pulse; dout0=dout1=0; state stays IDLE.
REQ-042 Spurious sdr_rdy in IDLE with sdr_data=64'hFFFF... -> no output change; busy stays 0.

Source files
------------

// File: rtl/sound_sdr_arb_pkg.sv
// Shared sound-subsystem types: arbiter state encoding and SDRAM line width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sound_sdr_arb_pkg;

    // Width of one SDRAM line as returned to the sound clients.
    localparam int LINE_W = 64;

    // Arbiter transaction states, also reused by the GA20 cache front end.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sdr_state_t;

endpackage

// File: rtl/sound_sdr_arb_pick.sv
// Grant selection between two requesters (fixed priority or round-robin).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module sound_sdr_arb_pick #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic vld,
    output logic sel
);

    // A lone requester always wins; on a tie either port 0 wins outright or
    // the port that was not served last wins (last=0 means port 0 went last).
    always_comb begin
        vld = req0 | req1;
        sel = req1;
        if (req0 && req1) begin
            sel = FIXED_PRIO ? 1'b0 : ~last;
        end
    end

endmodule

// File: rtl/sound_sdr_arb.sv
// Two-port arbiter sharing one SDRAM read channel for the sound engines.
// Latency: sdr_req one cycle after the IDLE sample; rdyN one cycle after sdr_rdy.
// Backpressure: requesters hold reqN/addrN until rdyN; sdr_req is held until sdr_rdy.
module sound_sdr_arb
    import sound_sdr_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int AW         = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [AW-1:0]     addr0,
    output logic              rdy0,
    output logic [LINE_W-1:0] dout0,
    input  logic              req1,
    input  logic [AW-1:0]     addr1,
    output logic              rdy1,
    output logic [LINE_W-1:0] dout1,
    output logic [AW-1:0]     sdr_addr,
    output logic              sdr_req,
    input  logic [LINE_W-1:0] sdr_data,
    input  logic              sdr_rdy,
    output logic              busy
);

    sdr_state_t        state, state_d;
    logic              gnt, gnt_d;        // granted port: 0 or 1
    logic              last, last_d;      // last served port
    logic              drop, drop_d;      // granted port abandoned its request
    logic              sdr_req_d;
    logic [AW-1:0]     sdr_addr_d;
    logic              rdy0_d, rdy1_d;
    logic [LINE_W-1:0] dout0_d, dout1_d;

    logic              pick_vld;
    logic              pick_sel;
    logic              gnt_req;

    sound_sdr_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .vld  (pick_vld),
        .sel  (pick_sel)
    );

    assign gnt_req = gnt ? req1 : req0;
    assign busy    = (state != ST_IDLE);

    // Next-state and next-output logic for the IDLE -> BUSY -> DONE cycle.
    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        last_d     = last;
        drop_d     = drop;
        sdr_req_d  = sdr_req;
        sdr_addr_d = sdr_addr;
        dout0_d    = dout0;
        dout1_d    = dout1;
        rdy0_d     = 1'b0;
        rdy1_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d    = ST_BUSY;
                    gnt_d      = pick_sel;
                    last_d     = pick_sel;
                    drop_d     = 1'b0;
                    sdr_req_d  = 1'b1;
                    sdr_addr_d = pick_sel ? addr1 : addr0;
                end
            end
            ST_BUSY: begin
                // A request that drops at any point in BUSY loses its rdy
                // pulse, but the SDRAM read still runs to completion.
                if (!gnt_req) begin
                    drop_d = 1'b1;
                end
                if (sdr_rdy) begin
                    state_d   = ST_DONE;
                    sdr_req_d = 1'b0;
                    if (gnt) begin
                        dout1_d = sdr_data;
                        rdy1_d  = gnt_req & ~drop;
                    end else begin
                        dout0_d = sdr_data;
                        rdy0_d  = gnt_req & ~drop;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                sdr_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any open transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            gnt      <= 1'b0;
            last     <= 1'b0;
            drop     <= 1'b0;
            sdr_req  <= 1'b0;
            sdr_addr <= '0;
            dout0    <= '0;
            dout1    <= '0;
            rdy0     <= 1'b0;
            rdy1     <= 1'b0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            last     <= last_d;
            drop     <= drop_d;
            sdr_req  <= sdr_req_d;
            sdr_addr <= sdr_addr_d;
            dout0    <= dout0_d;
            dout1    <= dout1_d;
            rdy0     <= rdy0_d;
            rdy1     <= rdy1_d;
        end
    end

endmodule
